fetch_decode_reg: RTL

FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_decode_reg.sv | 68 ++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch/decode boundary.
// Instruction format constants, FSM state encoding and word classification.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 32;

    localparam logic [2:0]  TWO_WORD_PREFIX = 3'b110;
    localparam logic [15:0] NOP_WORD        = 16'h0000;

    typedef enum logic [0:0] {
        S_WORD = 1'b0,
        S_IMM  = 1'b1
    } fd_state_t;

    function automatic logic is_two_word(input logic [15:0] word);
        return word[15:13] == TWO_WORD_PREFIX;
    endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register that assembles one- and two-word instructions.
// The immediate word of a two-word instruction is always treated as data.
module fetch_decode_reg
    import cpu_pkg::*;
#(
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int PC_W    = cpu_pkg::PC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    pc_plus_one,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [INSTR_W-1:0] id_immediate,
    output logic [PC_W-1:0]    id_pc_plus_one,
    output logic               id_valid,
    output logic               imm_pending
);

    fd_state_t          state;
    logic [INSTR_W-1:0] held_word;
    logic               two_word;

    assign two_word    = is_two_word(instruction[15:0]);
    assign imm_pending = (state == S_IMM);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state          <= S_WORD;
            held_word      <= '0;
            id_instruction <= INSTR_W'(NOP_WORD);
            id_immediate   <= '0;
            id_pc_plus_one <= '0;
            id_valid       <= 1'b0;
        end else if (!stall) begin
            // Default to a bubble; the cases below overwrite on completion.
            id_instruction <= INSTR_W'(NOP_WORD);
            id_immediate   <= '0;
            id_pc_plus_one <= '0;
            id_valid       <= 1'b0;
            unique case (1'b1)
                (state == S_WORD) && in_valid && !two_word: begin
                    id_instruction <= instruction;
                    id_pc_plus_one <= pc_plus_one;
                    id_valid       <= 1'b1;
                end
                (state == S_WORD) && in_valid && two_word: begin
                    held_word <= instruction;
                    state     <= S_IMM;
                end
                (state == S_IMM) && in_valid: begin
                    id_instruction <= held_word;
                    id_immediate   <= instruction;
                    id_pc_plus_one <= pc_plus_one;
                    id_valid       <= 1'b1;
                    held_word      <= '0;
                    state          <= S_WORD;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
